key_pio_irq: RTL and testbench

- Parametrised Avalon-MM slave for push-button/switch inputs; successor to the single-bit key PIO.
- Provides WIDTH channels, each with a 2-flop synchroniser, a per-channel debounce counter, a per-channel selectable edge type, per-bit IRQ mask and per-bit write-1-to-clear edge capture.
- Sits between board keys and the Nios II interrupt controller.

---
 rtl/key_pio_pkg.sv | 42 ++++
 rtl/key_debounce.sv | 83 ++++++++
 rtl/key_pio_irq.sv | 102 ++++++++++
 tb/tb_key_pio_irq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_pio_pkg
//  Description : Shared definitions for the key PIO interrupt block:
//                Avalon register addresses, the per-channel edge-mode
//                encoding and the edge-hit decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package key_pio_pkg;

    localparam logic [1:0] ADDR_DATA      = 2'd0;
    localparam logic [1:0] ADDR_EDGE_MODE = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP  = 2'd3;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    // Qualify a detected transition of one channel by its configured mode.
    function automatic logic edge_hit(
        input edge_mode_e mode,
        input logic       stable,
        input logic       stable_d
    );
        logic rise;
        logic fall;
        rise = stable & ~stable_d;
        fall = ~stable & stable_d;
        case (mode)
            EDGE_RISE: edge_hit = rise;
            EDGE_FALL: edge_hit = fall;
            EDGE_BOTH: edge_hit = rise | fall;
            default:   edge_hit = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : One key channel: 2-flop synchroniser, optional debounce
//                counter, accepted (stable) level and its one-cycle delay.
//                Macro KEY_PIO_DEBOUNCE_EN: when defined, a level must hold
//                DEBOUNCE_CYCLES consecutive cycles before it is accepted;
//                when undefined, the synchronised level is accepted every
//                cycle.
//  Ports       : clk      - system clock
//                reset_n  - asynchronous active-low reset
//                din      - raw asynchronous key input
//                stable   - accepted level
//                stable_d - accepted level delayed one clock
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic stable,
    output logic stable_d
);

    logic r_sync1;
    logic r_sync2;
    logic r_stable;
    logic r_stable_d;

    // Legal range is DEBOUNCE_CYCLES >= 2; nothing is built here.
    if (DEBOUNCE_CYCLES < 2) begin : g_range_note
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable_d <= 1'b0;
        end else begin
            r_sync1    <= din;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
        end
    end

`ifdef KEY_PIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Counter runs only while the synchronised level disagrees with the
    // accepted one; any return to the accepted level restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (r_sync2 == r_stable) begin
            r_cnt    <= '0;
        end else if (r_cnt == C_CNT_LAST) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
        end else begin
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= 1'b0;
        end else begin
            r_stable <= r_sync2;
        end
    end
`endif

    assign stable   = r_stable;
    assign stable_d = r_stable_d;

endmodule
`default_nettype wire

// File: rtl/key_pio_irq.sv
`default_nettype none
// ============================================================================
//  Module      : key_pio_irq
//  Description : Avalon-MM slave for WIDTH push-button/switch inputs with
//                per-channel debounce, selectable edge type, IRQ mask and
//                write-1-to-clear edge capture. Level interrupt output.
//                Macro KEY_PIO_DEBOUNCE_EN enables the debounce counters.
//  Ports       : clk, reset_n          - clock, async active-low reset
//                address[1:0]          - register select
//                chipselect, write_n   - Avalon write qualifiers
//                writedata[31:0]       - write data
//                in_port[WIDTH-1:0]    - raw key inputs
//                readdata[31:0]        - registered read data
//                irq                   - |(EDGE_CAPTURE & IRQ_MASK)
//  Revision    : 1.0 - initial release
// ============================================================================
module key_pio_irq
    import key_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0]   w_stable;
    logic [WIDTH-1:0]   w_stable_d;
    logic [WIDTH-1:0]   w_hit;
    logic [WIDTH-1:0]   w_clear;
    logic [31:0]        w_rdata;
    logic               w_wr;
    logic               w_unused_wdata;

    logic [2*WIDTH-1:0] r_edge_mode;
    logic [WIDTH-1:0]   r_irq_mask;
    logic [WIDTH-1:0]   r_edge_cap;

    assign w_wr           = chipselect & ~write_n;
    assign w_unused_wdata = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .reset_n  (reset_n),
            .din      (in_port[i]),
            .stable   (w_stable[i]),
            .stable_d (w_stable_d[i])
        );

        // Mode sampled in the same cycle the edge is seen: edges under
        // EDGE_OFF are dropped, never captured later.
        assign w_hit[i] = edge_hit(edge_mode_e'(r_edge_mode[2*i +: 2]),
                                   w_stable[i], w_stable_d[i]);
    end

    assign w_clear = (w_wr && address == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0]
                                                        : '0;

    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_DATA:      w_rdata[WIDTH-1:0]   = w_stable;
            ADDR_EDGE_MODE: w_rdata[2*WIDTH-1:0] = r_edge_mode;
            ADDR_IRQ_MASK:  w_rdata[WIDTH-1:0]   = r_irq_mask;
            ADDR_EDGE_CAP:  w_rdata[WIDTH-1:0]   = r_edge_cap;
            default:        w_rdata              = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_mode <= '0;
            r_irq_mask  <= '0;
            r_edge_cap  <= '0;
            readdata    <= '0;
        end else begin
            if (w_wr && address == ADDR_EDGE_MODE) begin
                r_edge_mode <= writedata[2*WIDTH-1:0];
            end
            if (w_wr && address == ADDR_IRQ_MASK) begin
                r_irq_mask <= writedata[WIDTH-1:0];
            end
            // OR-ing the hit after the clear lets a same-cycle edge win.
            r_edge_cap <= (r_edge_cap & ~w_clear) | w_hit;
            readdata   <= w_rdata;
        end
    end

    assign irq = |(r_edge_cap & r_irq_mask);

endmodule
`default_nettype wire

// File: tb/tb_key_pio_irq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_pio_irq
//  Description : Self-checking bench for key_pio_irq (WIDTH=4,
//                DEBOUNCE_CYCLES=16). Read expectations go through a
//                scoreboard queue. Sections depending on
//                KEY_PIO_DEBOUNCE_EN follow the same macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_pio_irq;

    localparam int WIDTH = 4;
    localparam int DEB   = 16;
    // Clock edges from driving a clean step to its capture bit being set:
    // first sampling edge, two sync stages / debounce, stable, capture.
`ifdef KEY_PIO_DEBOUNCE_EN
    localparam int CAP_EDGE = DEB + 3;
`else
    localparam int CAP_EDGE = 4;
`endif

    logic             clk        = 1'b0;
    logic             reset_n    = 1'b0;
    logic [1:0]       address    = 2'd0;
    logic             chipselect = 1'b0;
    logic             write_n    = 1'b1;
    logic [31:0]      writedata  = '0;
    logic [WIDTH-1:0] in_port    = '0;
    logic [31:0]      readdata;
    logic             irq;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    key_pio_irq #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance n clock edges, landing 1 time unit after the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic [1:0] a, input string tag,
                      input logic [31:0] v);
        exp_t e;
        exp_q.push_back('{tag: tag, val: v});
        address = a;
        step(1);
        e = exp_q.pop_front();
        check(e.tag, readdata, e.val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;

        // ---------------- reset, then reset in the middle of traffic
        step(3);
        reset_n = 1'b1;
        step(1);
        wr(1, 32'h01);
        wr(2, 32'h01);
        in_port[0] = 1'b1;
        step(CAP_EDGE + 2);
        check("pre_rst_irq", 32'(irq), 32'h1);
        rd(3, "pre_rst_cap", 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        in_port = '0;
        step(2);
        reset_n = 1'b1;
        rd(0, "post_rst_data", 32'h0);
        rd(1, "post_rst_mode", 32'h0);
        rd(2, "post_rst_mask", 32'h0);
        rd(3, "post_rst_cap",  32'h0);

        // ---------------- falling edge on ch2 with irq
        wr(1, 32'h20);
        wr(2, 32'h04);
        in_port[2] = 1'b1;
        step(30);
        rd(3, "fall_no_rise", 32'h0);
        rd(0, "fall_data_hi", 32'h4);
        in_port[2] = 1'b0;
        step(30);
        rd(3, "fall_cap", 32'h4);
        check("fall_irq", 32'(irq), 32'h1);
        wr(3, 32'h0);
        rd(3, "w1c_zero", 32'h4);
        check("w1c_zero_irq", 32'(irq), 32'h1);
        wr(3, 32'h4);
        check("w1c_irq_drop", 32'(irq), 32'h0);
        rd(3, "w1c_cleared", 32'h0);
        wr(0, 32'hF);
        rd(0, "data_ro", 32'h0);

        // ---------------- set wins over a same-cycle clear on ch1
        wr(1, 32'h04);
        wr(3, 32'hF);
        in_port[1] = 1'b1;
        step(CAP_EDGE - 1);
        wr(3, 32'h2);
        rd(3, "set_wins", 32'h2);
        wr(3, 32'h2);
        rd(3, "set_wins_clr", 32'h0);

        // ---------------- both edges on ch3, mask off
        wr(2, 32'h0);
        wr(1, 32'hC0);
        in_port[3] = 1'b1;
        step(40);
        rd(3, "both_rise", 32'h8);
        check("both_rise_irq", 32'(irq), 32'h0);
        wr(3, 32'h8);
        rd(3, "both_clr", 32'h0);
        in_port[3] = 1'b0;
        step(40);
        rd(3, "both_fall", 32'h8);
        check("both_fall_irq", 32'(irq), 32'h0);
        wr(2, 32'h8);
        check("unmask_irq", 32'(irq), 32'h1);

        // ---------------- return to idle
        in_port = '0;
        step(40);
        wr(2, 32'h0);
        wr(3, 32'hF);

`ifdef KEY_PIO_DEBOUNCE_EN
        // ---------------- bounce rejection on ch0
        wr(1, 32'h01);
        rd(3, "bounce_pre", 32'h0);
        for (int i = 0; i < 8; i++) begin
            in_port[0] = ~in_port[0];
            step(5);
        end
        in_port[0] = 1'b1;
        address    = 2'd0;
        n = 0;
        while (readdata[0] !== 1'b1 && n < 60) begin
            step(1);
            n++;
        end
        // Sampling edge, then 2 sync + DEB debounce clocks.
        check("bounce_lat", 32'(n), 32'(1 + 2 + DEB));
        step(2);
        rd(3, "bounce_cap", 32'h1);
        wr(3, 32'h1);
        step(40);
        rd(3, "bounce_once", 32'h0);
`else
        // ---------------- no debounce: glitches are captured
        wr(1, 32'h05);
        wr(2, 32'h03);
        in_port[0] = 1'b1;
        step(1);
        in_port[0] = 1'b0;
        step(6);
        check("glitch_irq", 32'(irq), 32'h1);
        rd(3, "glitch_cap", 32'h1);
        wr(3, 32'h1);
        check("glitch_clr_irq", 32'(irq), 32'h0);
        in_port[1] = 1'b1;
        n = 0;
        while (irq !== 1'b1 && n < 12) begin
            step(1);
            n++;
            if (n == 3) in_port[1] = 1'b0;
        end
        // Capture set 3 clocks after the edge that first samples the pulse.
        check("pulse_lat", 32'(n), 32'(1 + 3));
        rd(3, "pulse_cap", 32'h2);
`endif

        // ---------------- unused register bits read as zero
        wr(1, 32'hFFFF_FFFF);
        rd(1, "mode_width", 32'hFF);
        wr(2, 32'hFFFF_FFFF);
        rd(2, "mask_width", 32'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
